// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised integer register file with init sequencer, x0 and write bypass
// Reads are forced to 0 until the post-reset scan has visited every entry.
module regfile_param #(
  parameter int XLEN      = 64,
  parameter int NREGS     = 32,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 0,
  parameter int AW        = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] writeData,
  input  logic            regWrite,
  output logic [XLEN-1:0] readData1,
  output logic [XLEN-1:0] readData2,
  output logic            ready
);

  localparam logic [0:0]    ST_INIT = 1'b0;
  localparam logic [0:0]    ST_RUN  = 1'b1;
  localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

  logic [0:0]      state;
  logic [AW-1:0]   init_cnt;
  logic [XLEN-1:0] init_val;
  logic            user_we;
  logic            run;
  logic [XLEN-1:0] mem [NREGS];

  assign run      = (state == ST_RUN);
  assign init_val = (INIT_MODE != 0) ? XLEN'(init_cnt) : '0;
  assign user_we  = regWrite && !((ZERO_REG != 0) && (rd == '0));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == LAST) begin
        state <= ST_RUN;
        ready <= 1'b1;
      end
    end
  end

  // Storage has no reset: the scan overwrites every entry before reads are released.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (!run) begin
        mem[init_cnt] <= init_val;
      end else if (user_we) begin
        mem[rd] <= writeData;
      end
    end
  end

  always_comb begin
    readData1 = '0;
    if (run) begin
      if ((ZERO_REG != 0) && (rs1 == '0)) begin
        readData1 = '0;
      end else if ((BYPASS != 0) && regWrite && (rd == rs1)) begin
        readData1 = writeData;
      end else begin
        readData1 = mem[rs1];
      end
    end
  end

  always_comb begin
    readData2 = '0;
    if (run) begin
      if ((ZERO_REG != 0) && (rs2 == '0)) begin
        readData2 = '0;
      end else if ((BYPASS != 0) && regWrite && (rd == rs2)) begin
        readData2 = writeData;
      end else begin
        readData2 = mem[rs2];
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - scoreboard bench for regfile_param, two parameterisations driven in lockstep
module tb_regfile_param;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic [AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] writeData;
  logic            regWrite;
  logic [XLEN-1:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic            a_ready, b_ready;

  always #5 clock = ~clock;

  // a: x0 hardwired, bypass on, entry i inits to i;  b: plain x0, no bypass, zero init
  regfile_param #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1), .BYPASS(1), .INIT_MODE(1)) dut_a (
    .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
    .writeData(writeData), .regWrite(regWrite),
    .readData1(a_rd1), .readData2(a_rd2), .ready(a_ready)
  );

  regfile_param #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(0), .BYPASS(0), .INIT_MODE(0)) dut_b (
    .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
    .writeData(writeData), .regWrite(regWrite),
    .readData1(b_rd1), .readData2(b_rd2), .ready(b_ready)
  );

  typedef struct {
    string       tag;
    logic        rdy;
    logic [63:0] a1, a2, b1, b2;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] ma [NREGS];
  logic [63:0] mb [NREGS];
  int          since_rel;
  bit          mrdy;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input string what, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%h required=%h", tag, what, act, req);
    end
  endtask

  function automatic logic [63:0] exp_a(input logic [AW-1:0] rs);
    if (!mrdy || rs == 0) return 64'h0;
    if (regWrite && rd == rs) return writeData;
    return ma[rs];
  endfunction

  function automatic logic [63:0] exp_b(input logic [AW-1:0] rs);
    if (!mrdy) return 64'h0;
    return mb[rs];
  endfunction

  // Model: after NREGS consecutive reset-high edges the whole array holds the init pattern.
  task automatic model_edge();
    if (!reset) begin
      since_rel = 0;
      mrdy      = 1'b0;
    end else if (!mrdy) begin
      since_rel++;
      if (since_rel == NREGS) begin
        for (int i = 0; i < NREGS; i++) begin
          ma[i] = 64'(i);
          mb[i] = 64'h0;
        end
        mrdy = 1'b1;
      end
    end else if (regWrite) begin
      if (rd != 0) ma[rd] = writeData;
      mb[rd] = writeData;
    end
  endtask

  task automatic step(input string tag);
    exp_t e;
    e.tag = tag;
    e.rdy = mrdy;
    e.a1  = exp_a(rs1);
    e.a2  = exp_a(rs2);
    e.b1  = exp_b(rs1);
    e.b2  = exp_b(rs2);
    sb.push_back(e);
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic [AW-1:0] d,
                       input logic [63:0] wd, input logic we);
    rs1 = r1; rs2 = r2; rd = d; writeData = wd; regWrite = we;
  endtask

  task automatic drive_rand();
    logic [AW-1:0] d;
    d = AW'($urandom_range(0, NREGS - 1));
    drive(($urandom_range(0, 3) == 0) ? d : AW'($urandom_range(0, NREGS - 1)),
          ($urandom_range(0, 3) == 0) ? d : AW'($urandom_range(0, NREGS - 1)),
          d, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.tag, "a_ready", {63'h0, a_ready}, {63'h0, e.rdy});
        check(e.tag, "b_ready", {63'h0, b_ready}, {63'h0, e.rdy});
        check(e.tag, "a_rd1", a_rd1, e.a1);
        check(e.tag, "a_rd2", a_rd2, e.a2);
        check(e.tag, "b_rd1", b_rd1, e.b1);
        check(e.tag, "b_rd2", b_rd2, e.b2);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset = 1'b0;
    drive('0, '0, '0, '0, 1'b0);
    since_rel = 0;
    mrdy      = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 3; i++) begin
      drive_rand();
      step("reset_low");
    end

    reset = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      drive_rand();
      if (i == 4) drive(5'd9, 5'd9, 5'd9, 64'h1234, 1'b1);
      step("init");
    end

    drive(5'd5, 5'd31, 5'd0, 64'h0, 1'b0);  step("init_vals");
    drive(5'd0, 5'd9, 5'd0, 64'h0, 1'b0);   step("x0_and_r9");
    drive(5'd7, 5'd6, 5'd7, 64'hDEAD_BEEF, 1'b1); step("bypass_same");
    drive(5'd7, 5'd7, 5'd0, 64'h0, 1'b0);   step("bypass_next");
    drive(5'd0, 5'd1, 5'd0, 64'hFFFF, 1'b1); step("wr_x0_same");
    drive(5'd0, 5'd0, 5'd0, 64'h0, 1'b0);   step("wr_x0_next");
    drive(5'd12, 5'd12, 5'd12, 64'hA5, 1'b1); step("dual_bypass");
    drive(5'd12, 5'd12, 5'd0, 64'h0, 1'b0); step("dual_after");
    drive(5'd3, 5'd2, 5'd3, 64'h55, 1'b1);  step("wr_r3");
    drive(5'd3, 5'd3, 5'd0, 64'h0, 1'b0);   step("rd_r3");

    for (int i = 0; i < 150; i++) begin
      drive_rand();
      step("random_run");
    end

    reset = 1'b0;
    drive_rand();
    step("reset_pulse");
    reset = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      drive_rand();
      step("reinit");
    end
    drive(5'd3, 5'd0, 5'd0, 64'h0, 1'b0);   step("r3_reinit");

    for (int i = 0; i < 100; i++) begin
      drive_rand();
      step("random_run2");
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
